alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared external 4-bit ALU.
// Each operation runs IDLE -> EXEC -> RESP, one op per three cycles.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] op0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [3:0] op1,
  input  logic [3:0] alu_y,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam int unsigned DW = 4;
  localparam int unsigned OW = 4;
  localparam int unsigned CW = 8;
  localparam logic [OW-1:0] OP_ZERO = OW'(10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_owner, w_owner_nxt;   // 1: requester 1 owns the ALU
  logic          r_last,  w_last_nxt;    // last requester served
  logic          r_gnt0,  w_gnt0_nxt;
  logic          r_gnt1,  w_gnt1_nxt;
  logic          r_done0, w_done0_nxt;
  logic          r_done1, w_done1_nxt;
  logic          r_busy,  w_busy_nxt;
  logic [DW-1:0] r_y0,    w_y0_nxt;
  logic [DW-1:0] r_y1,    w_y1_nxt;
  logic [DW-1:0] r_alu_a, w_alu_a_nxt;
  logic [DW-1:0] r_alu_b, w_alu_b_nxt;
  logic [OW-1:0] r_alu_op, w_alu_op_nxt;
  logic [CW-1:0] r_op_count, w_op_count_nxt;

  // Next-state and next-output logic; the ALU operand registers double as the capture registers.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_done0_nxt    = 1'b0;
    w_done1_nxt    = 1'b0;
    w_y0_nxt       = r_y0;
    w_y1_nxt       = r_y1;
    w_alu_a_nxt    = '0;
    w_alu_b_nxt    = '0;
    w_alu_op_nxt   = OP_ZERO;
    w_op_count_nxt = r_op_count;

    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_owner_nxt = (req0 && req1) ? ~r_last : req1;
          w_state_nxt = S_EXEC;
          if (w_owner_nxt) begin
            w_alu_a_nxt  = a1;
            w_alu_b_nxt  = b1;
            w_alu_op_nxt = op1;
          end else begin
            w_alu_a_nxt  = a0;
            w_alu_b_nxt  = b0;
            w_alu_op_nxt = op0;
          end
        end
      end
      S_EXEC: begin
        if (r_owner) begin
          w_y1_nxt    = alu_y;
          w_done1_nxt = 1'b1;
        end else begin
          w_y0_nxt    = alu_y;
          w_done0_nxt = 1'b1;
        end
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_last_nxt     = r_owner;
        w_op_count_nxt = r_op_count + CW'(1);
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_gnt0_nxt = w_busy_nxt && !w_owner_nxt;
    w_gnt1_nxt = w_busy_nxt &&  w_owner_nxt;
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_busy     <= 1'b0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= OP_ZERO;
      r_op_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_gnt0     <= w_gnt0_nxt;
      r_gnt1     <= w_gnt1_nxt;
      r_done0    <= w_done0_nxt;
      r_done1    <= w_done1_nxt;
      r_busy     <= w_busy_nxt;
      r_y0       <= w_y0_nxt;
      r_y1       <= w_y1_nxt;
      r_alu_a    <= w_alu_a_nxt;
      r_alu_b    <= w_alu_b_nxt;
      r_alu_op   <= w_alu_op_nxt;
      r_op_count <= w_op_count_nxt;
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign busy     = r_busy;
  assign y0       = r_y0;
  assign y1       = r_y1;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

  logic       clk, rst, req0, req1;
  logic [3:0] a0, b0, op0, a1, b1, op1, alu_y;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] y0, y1, alu_a, alu_b, alu_op;
  logic [7:0] op_count;

  int n_vec = 0;
  int n_miss = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .alu_y(alu_y), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .y0(y0), .y1(y1), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 9 pass a, else zero.
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return 4'(a + b);
      4'd1:    return 4'(a - b);
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd9:    return a;
      default: return 4'd0;
    endcase
  endfunction

  always_comb alu_y = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: cycles left in the current operation (0 = free).
  int         m_left = 0;
  int         m_cnt  = 0;
  logic       m_own  = 1'b0;
  logic       m_last = 1'b1;
  logic [3:0] m_a = '0, m_b = '0, m_op = '0;
  logic [3:0] m_y [2] = '{4'd0, 4'd0};

  task automatic model_edge();
    if (rst) begin
      m_left = 0; m_last = 1'b1; m_cnt = 0; m_y[0] = 4'd0; m_y[1] = 4'd0;
    end else if (m_left == 0) begin
      if (req0 || req1) begin
        m_own = (req0 && req1) ? !m_last : req1;
        if (m_own) begin m_a = a1; m_b = b1; m_op = op1; end
        else       begin m_a = a0; m_b = b0; m_op = op0; end
        m_left = 2;
      end
    end else if (m_left == 2) begin
      m_y[m_own] = alu_f(m_a, m_b, m_op);
      m_left = 1;
    end else begin
      m_last = m_own;
      m_cnt  = (m_cnt + 1) % 256;
      m_left = 0;
    end
  endtask

  // One clock: update the model with the inputs the DUT samples, then compare everything.
  task automatic step();
    logic [32:0] e, a;
    model_edge();
    @(posedge clk); #1;
    e = {m_left != 0 && !m_own, m_left != 0 && m_own, m_left == 1 && !m_own,
         m_left == 1 && m_own, m_left != 0, m_y[0], m_y[1],
         (m_left == 2) ? m_a : 4'd0, (m_left == 2) ? m_b : 4'd0,
         (m_left == 2) ? m_op : 4'd10, 8'(m_cnt)};
    a = {gnt0, gnt1, done0, done1, busy, y0, y1, alu_a, alu_b, alu_op, op_count};
    chk("model", 64'(a), 64'(e));
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst, req0, req1;
    logic [3:0] a0, b0, op0, a1, b1, op1;
    logic       e_g0, e_g1, e_d0, e_d1;
    logic [3:0] e_y0, e_y1;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [8];
  int   done_edges [$];
  int   done_who [$];

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;

    // Directed table: reset, add on requester 0, wrapping subtract on requester 1.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd7, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd7, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 4'h0, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 4'd7, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 4'h0, 8'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB, 4'h0, 8'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hB, 4'hD, 8'd1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 4'hD, 8'd2};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 4'hD, 8'd2};

    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; req0 = tbl[i].req0; req1 = tbl[i].req1;
      a0 = tbl[i].a0; b0 = tbl[i].b0; op0 = tbl[i].op0;
      a1 = tbl[i].a1; b1 = tbl[i].b1; op1 = tbl[i].op1;
      step();
      chk($sformatf("table[%0d]", i),
          64'({gnt0, gnt1, done0, done1, y0, y1, op_count}),
          64'({tbl[i].e_g0, tbl[i].e_g1, tbl[i].e_d0, tbl[i].e_d1, tbl[i].e_y0, tbl[i].e_y1, tbl[i].e_cnt}));
    end
    chk("idle_alu_ports", 64'({alu_a, alu_b, alu_op}), 64'(12'h00A));

    // Both requesters held continuously: alternate starting with 0, done pulses 3 cycles apart.
    do_reset();
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd2; op0 = 4'd0;
    req1 = 1'b1; a1 = 4'd5; b1 = 4'd3; op1 = 4'd2;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("done_exclusive", 64'(done0 && done1), 64'(0));
      if (done0 || done1) begin
        done_edges.push_back(e);
        done_who.push_back(done1 ? 1 : 0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_count", 64'(done_edges.size()), 64'(4));
    for (int k = 0; k < 4 && k < done_edges.size(); k++) begin
      chk($sformatf("rr_edge[%0d]", k), 64'(done_edges[k]), 64'(2 + 3 * k));
      chk($sformatf("rr_who[%0d]", k), 64'(done_who[k]), 64'(k % 2));
    end
    step(); step();

    // Reset during EXEC abandons the operation.
    do_reset();
    req0 = 1'b1; a0 = 4'd7; b0 = 4'd4; op0 = 4'd0;
    step();
    chk("exec_alu_ports", 64'({gnt0, alu_a, alu_b, alu_op}), 64'({1'b1, 12'h740}));
    rst = 1'b1; req0 = 1'b0;
    step();
    chk("rst_abort", 64'({gnt0, done0, busy, y0, op_count, alu_op}), 64'({3'b000, 4'h0, 8'd0, 4'hA}));
    rst = 1'b0;
    step();
    chk("rst_no_done", 64'({done0, y0, op_count}), 64'(0));

    // Operand change after capture does not affect the result.
    req0 = 1'b1; a0 = 4'd7; b0 = 4'd0; op0 = 4'd9;
    step();
    a0 = 4'd1;
    step();
    chk("capture_hold", 64'({done0, y0}), 64'({1'b1, 4'h7}));
    req0 = 1'b0;
    step();

    // Request dropped during EXEC still completes.
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd2; op1 = 4'd0;
    step();
    req1 = 1'b0;
    step();
    chk("drop_completes", 64'({done1, y1}), 64'({1'b1, 4'h5}));
    step();

    // 256 back-to-back ops wrap the counter.
    do_reset();
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd1; op0 = 4'd0;
    for (int e = 1; e <= 768; e++) begin
      step();
      if (e == 765) chk("cnt_255", 64'(op_count), 64'(255));
    end
    req0 = 1'b0;
    chk("cnt_wrap", 64'(op_count), 64'(0));
    step();

    // Randomized protocol-abiding traffic with occasional resets and early drops.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (done0 || ($urandom_range(0, 31) == 0)) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom); op0 = 4'($urandom);
      end else if (req0 && $urandom_range(0, 7) == 0) a0 = 4'($urandom);
      if (done1 || ($urandom_range(0, 31) == 0)) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom); op1 = 4'($urandom);
      end else if (req1 && $urandom_range(0, 7) == 0) b1 = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
